// File: rtl/dac_frame_sequencer.sv
// dac_frame_sequencer: converts N-bit two's-complement filter results into 8-bit
// offset-binary DAC codes and shifts each one out as a 16-bit SPI frame
// {CMD, code, 4'b0000}, MSB first. A one-entry holding buffer lets the next
// sample arrive while the current frame is still being shifted out.
module dac_frame_sequencer #(
    parameter int         N   = 16,
    parameter int         DIV = 2,
    parameter logic [3:0] CMD = 4'b0011
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         dac_cs_n,
    output logic         dac_sclk,
    output logic         dac_sdo,
    output logic         busy,
    output logic         frame_done,
    output logic         overrun,
    output logic [7:0]   last_code
);

    localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_END,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [15:0]   shift_q, shift_d;
    logic          buf_full_q, buf_full_d;
    logic [7:0]    buf_code_q, buf_code_d;
    logic          cs_n_q, cs_n_d;
    logic          sclk_q, sclk_d;
    logic          busy_q, busy_d;
    logic          frame_done_q, frame_done_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    last_code_q, last_code_d;

    logic          accept;
    logic          cnt_wrap;
    logic [7:0]    din_code;

    // Offset-binary reduction: flip the sign bit, keep the top 8 bits.
    assign din_code = {~din[N-1], din[N-2:N-8]};
    assign accept   = din_valid & ~buf_full_q;
    assign cnt_wrap = (cnt_q == CNT_LAST);

    // Bits below the top eight are intentionally discarded.
    if (N > 8) begin : g_lsbs
        logic unused_lsbs;
        assign unused_lsbs = ^din[N-9:0];
    end

    // Next-state computation for buffer, frame FSM and all registered outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        buf_full_d   = buf_full_q;
        buf_code_d   = buf_code_q;
        cs_n_d       = cs_n_q;
        sclk_d       = sclk_q;
        busy_d       = busy_q;
        last_code_d  = last_code_q;
        frame_done_d = 1'b0;
        overrun_d    = din_valid & buf_full_q;

        if (accept) begin
            buf_full_d = 1'b1;
            buf_code_d = din_code;
        end

        case (state_q)
            S_IDLE: begin
                // The buffer never accepts while full, so freeing here cannot
                // collide with a same-edge accept.
                if (buf_full_q) begin
                    state_d     = S_SETUP;
                    buf_full_d  = 1'b0;
                    shift_d     = {CMD, buf_code_q, 4'b0000};
                    cs_n_d      = 1'b0;
                    sclk_d      = 1'b0;
                    busy_d      = 1'b1;
                    last_code_d = buf_code_q;
                    cnt_d       = '0;
                end
            end
            S_SETUP: begin
                if (cnt_wrap) begin
                    cnt_d   = '0;
                    state_d = S_SHIFT;
                    sclk_d  = 1'b1;
                    bit_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt_wrap) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        // Falling sclk: present the next bit for the next rise.
                        sclk_d  = 1'b0;
                        shift_d = {shift_q[14:0], 1'b0};
                    end else if (bit_q == 4'd15) begin
                        state_d      = S_END;
                        cs_n_d       = 1'b1;
                        frame_done_d = 1'b1;
                        shift_d      = '0;
                    end else begin
                        sclk_d = 1'b1;
                        bit_d  = bit_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_END: begin
                state_d = S_GAP;
                cnt_d   = '0;
            end
            S_GAP: begin
                if (cnt_wrap) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= 4'd0;
            shift_q      <= '0;
            buf_full_q   <= 1'b0;
            buf_code_q   <= 8'h00;
            cs_n_q       <= 1'b1;
            sclk_q       <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            last_code_q  <= 8'h80;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            buf_full_q   <= buf_full_d;
            buf_code_q   <= buf_code_d;
            cs_n_q       <= cs_n_d;
            sclk_q       <= sclk_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
            last_code_q  <= last_code_d;
        end
    end

    assign din_ready  = ~buf_full_q;
    assign dac_cs_n   = cs_n_q;
    assign dac_sclk   = sclk_q;
    assign dac_sdo    = shift_q[15];
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    assign last_code  = last_code_q;

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Bench for dac_frame_sequencer: two instances (DIV=2 and DIV=1), a pin-level
// frame decoder and a reference model that derives codes and timing arithmetically.
`timescale 1ns/1ps
module tb_dac_frame_sequencer;

    localparam int NU = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   din;
    logic [NU-1:0] din_valid;
    logic [NU-1:0] din_ready, cs_n, sclk, sdo, busy, frame_done, overrun;
    logic [7:0]    last_code [NU];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NU; gi++) begin : g_dut
            dac_frame_sequencer #(
                .N  (16),
                .DIV((gi == 0) ? 2 : 1),
                .CMD(4'b0011)
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .din       (din),
                .din_valid (din_valid[gi]),
                .din_ready (din_ready[gi]),
                .dac_cs_n  (cs_n[gi]),
                .dac_sclk  (sclk[gi]),
                .dac_sdo   (sdo[gi]),
                .busy      (busy[gi]),
                .frame_done(frame_done[gi]),
                .overrun   (overrun[gi]),
                .last_code (last_code[gi])
            );
        end
    endgenerate

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // stimulus queue: value, idle cycles before presenting, drop-allowed flag
    logic [15:0] st_din [$];
    int          st_dly [$];
    bit          st_nw  [$];

    // model expectations
    logic [7:0]  exp_code [$];
    int          exp_ovr_cyc [$];

    // decoded pin activity
    bit          prev_cs, prev_sclk, prev_busy, seen_frame;
    logic [15:0] cur_word;
    int          cur_rises, cur_low, gap_len, gap_min, tail, done_cnt, busy_err;
    logic [15:0] fr_word [$];
    int          fr_rises [$];
    int          fr_low [$];
    bit          fr_done [$];
    int          fr_start [$];
    logic [7:0]  fr_last [$];
    int          tails [$];
    int          ovr_cyc [$];

    function automatic int div_of(input int u);
        return (u == 0) ? 2 : 1;
    endfunction

    // Offset binary: shift the signed range up by half scale, keep the top byte.
    function automatic logic [7:0] ref_code(input logic [15:0] x);
        int v;
        v = $signed(x);
        return 8'((v + 32768) / 256);
    endfunction

    function automatic logic [15:0] ref_frame(input logic [7:0] c);
        return {4'h3, c, 4'h0};
    endfunction

    task automatic clr_mon(input int u);
        st_din.delete(); st_dly.delete(); st_nw.delete();
        exp_code.delete(); exp_ovr_cyc.delete();
        fr_word.delete(); fr_rises.delete(); fr_low.delete(); fr_done.delete();
        fr_start.delete(); fr_last.delete(); tails.delete(); ovr_cyc.delete();
        prev_cs = cs_n[u]; prev_sclk = sclk[u]; prev_busy = busy[u];
        seen_frame = 0; cur_word = '0; cur_rises = 0; cur_low = 0;
        gap_len = 0; gap_min = 1000000; tail = 0; done_cnt = 0; busy_err = 0;
    endtask

    task automatic push_stim(input logic [15:0] v, input int dly, input bit nw);
        st_din.push_back(v); st_dly.push_back(dly); st_nw.push_back(nw);
    endtask

    // One clock: observe pins at the falling edge, then drive for the next rise.
    task automatic step(input int u);
        @(negedge clk);
        cyc++;
        if (!cs_n[u]) begin
            if (prev_cs) begin
                cur_word = '0; cur_rises = 0; cur_low = 0;
                fr_start.push_back(cyc);
                fr_last.push_back(last_code[u]);
                if (seen_frame && gap_len < gap_min) gap_min = gap_len;
            end
            cur_low++;
            if (sclk[u] && !prev_sclk) begin
                cur_word = {cur_word[14:0], sdo[u]};
                cur_rises++;
            end
            if (!busy[u]) busy_err++;
        end else begin
            if (!prev_cs) begin
                fr_word.push_back(cur_word); fr_rises.push_back(cur_rises);
                fr_low.push_back(cur_low); fr_done.push_back(frame_done[u]);
                seen_frame = 1; gap_len = 0;
            end
            gap_len++;
            if (busy[u]) tail++;
        end
        if (prev_busy && !busy[u]) begin
            tails.push_back(tail);
            tail = 0;
        end
        done_cnt += int'(frame_done[u]);
        if (overrun[u]) ovr_cyc.push_back(cyc);
        prev_cs = cs_n[u]; prev_sclk = sclk[u]; prev_busy = busy[u];

        din_valid = '0;
        if (st_din.size() > 0 && !reset) begin
            if (st_dly[0] > 0) begin
                st_dly[0] = st_dly[0] - 1;
            end else if (din_ready[u] || st_nw[0]) begin
                din = st_din[0];
                din_valid[u] = 1'b1;
                if (din_ready[u]) begin
                    exp_code.push_back(ref_code(st_din[0]));
                    $display("tx unit=%0d din=%h code=%h accepted", u, st_din[0], ref_code(st_din[0]));
                end else begin
                    exp_ovr_cyc.push_back(cyc + 1);
                    $display("tx unit=%0d din=%h dropped", u, st_din[0]);
                end
                void'(st_din.pop_front()); void'(st_dly.pop_front()); void'(st_nw.pop_front());
            end
        end
    endtask

    task automatic run(input int u, input int maxc);
        int c;
        int idle;
        idle = 0;
        for (c = 0; c < maxc; c++) begin
            step(u);
            if (st_din.size() == 0 && !busy[u] && din_ready[u] && cs_n[u]) idle++;
            else idle = 0;
            if (idle >= 4) break;
        end
        total++;
        if (c >= maxc) begin
            bad++;
            $display("FAIL run_timeout unit=%0d got=%0d cycles required=<%0d", u, c, maxc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; din = '0; din_valid = '0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            total++;
            if ({cs_n[u], sclk[u], sdo[u], busy[u], frame_done[u], overrun[u], din_ready[u]} !== 7'b1000001) begin
                bad++;
                $display("FAIL reset_pins unit=%0d got=%b required=1000001", u,
                         {cs_n[u], sclk[u], sdo[u], busy[u], frame_done[u], overrun[u], din_ready[u]});
            end
            total++;
            if (last_code[u] !== 8'h80) begin
                bad++;
                $display("FAIL reset_last_code unit=%0d got=%h required=80", u, last_code[u]);
            end
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int u = 0; u < NU; u++) begin
            total++;
            if ({cs_n[u], busy[u], din_ready[u]} !== 3'b101) begin
                bad++;
                $display("FAIL idle_after_reset unit=%0d got=%b required=101", u, {cs_n[u], busy[u], din_ready[u]});
            end
        end
    endtask

    task automatic test_codes(input int u);
        logic [15:0] dir [4];
        int d;
        d = div_of(u);
        dir[0] = 16'h0000; dir[1] = 16'h7FFF; dir[2] = 16'h8000; dir[3] = 16'hFFFF;
        clr_mon(u);
        for (int i = 0; i < 4; i++) push_stim(dir[i], $urandom_range(0, 20), 1'b0);
        for (int i = 0; i < 4; i++) push_stim(16'($urandom), $urandom_range(0, 80), 1'b0);
        run(u, 4000);
        total++;
        if (fr_word.size() != exp_code.size() || exp_code.size() != 8) begin
            bad++;
            $display("FAIL codes_count unit=%0d got=%0d required=%0d", u, fr_word.size(), exp_code.size());
        end
        for (int i = 0; i < fr_word.size() && i < exp_code.size(); i++) begin
            $display("frame unit=%0d word=%h rises=%0d low=%0d done=%0d", u, fr_word[i], fr_rises[i], fr_low[i], fr_done[i]);
            total++;
            if (fr_word[i] !== ref_frame(exp_code[i])) begin
                bad++;
                $display("FAIL codes_word unit=%0d idx=%0d got=%h required=%h", u, i, fr_word[i], ref_frame(exp_code[i]));
            end
            total++;
            if (fr_rises[i] != 16 || fr_low[i] != 33 * d || fr_done[i] !== 1'b1) begin
                bad++;
                $display("FAIL codes_timing unit=%0d idx=%0d got=rises%0d/low%0d/done%0d required=16/%0d/1",
                         u, i, fr_rises[i], fr_low[i], fr_done[i], 33 * d);
            end
            total++;
            if (fr_last[i] !== exp_code[i]) begin
                bad++;
                $display("FAIL codes_last_code unit=%0d idx=%0d got=%h required=%h", u, i, fr_last[i], exp_code[i]);
            end
        end
        for (int i = 0; i < tails.size(); i++) begin
            total++;
            if (tails[i] != d + 1) begin
                bad++;
                $display("FAIL codes_busy_tail unit=%0d idx=%0d got=%0d required=%0d", u, i, tails[i], d + 1);
            end
        end
        total++;
        if (done_cnt != exp_code.size() || busy_err != 0 || ovr_cyc.size() != 0) begin
            bad++;
            $display("FAIL codes_flags unit=%0d got=done%0d/busyerr%0d/ovr%0d required=%0d/0/0",
                     u, done_cnt, busy_err, ovr_cyc.size(), exp_code.size());
        end
    endtask

    task automatic test_back_to_back(input int u);
        int d;
        d = div_of(u);
        clr_mon(u);
        push_stim(16'($urandom), 0, 1'b0);
        push_stim(16'($urandom), 0, 1'b0);
        run(u, 2000);
        total++;
        if (fr_word.size() != 2 || exp_code.size() != 2) begin
            bad++;
            $display("FAIL b2b_count unit=%0d got=%0d required=2", u, fr_word.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                total++;
                if (fr_word[i] !== ref_frame(exp_code[i])) begin
                    bad++;
                    $display("FAIL b2b_order unit=%0d idx=%0d got=%h required=%h", u, i, fr_word[i], ref_frame(exp_code[i]));
                end
            end
            total++;
            if (fr_start[1] - fr_start[0] != 34 * d + 2) begin
                bad++;
                $display("FAIL b2b_period unit=%0d got=%0d required=%0d", u, fr_start[1] - fr_start[0], 34 * d + 2);
            end
            total++;
            if (gap_min < d) begin
                bad++;
                $display("FAIL b2b_gap unit=%0d got=%0d required>=%0d", u, gap_min, d);
            end
        end
        total++;
        if (ovr_cyc.size() != 0) begin
            bad++;
            $display("FAIL b2b_overrun unit=%0d got=%0d required=0", u, ovr_cyc.size());
        end
    endtask

    task automatic test_overrun(input int u);
        clr_mon(u);
        push_stim(16'($urandom), 0, 1'b0);
        push_stim(16'($urandom), 0, 1'b0);
        push_stim(16'($urandom), 10, 1'b1);
        run(u, 2000);
        total++;
        if (fr_word.size() != 2 || exp_code.size() != 2) begin
            bad++;
            $display("FAIL ovr_frames unit=%0d got=%0d required=2", u, fr_word.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                total++;
                if (fr_word[i] !== ref_frame(exp_code[i])) begin
                    bad++;
                    $display("FAIL ovr_word unit=%0d idx=%0d got=%h required=%h", u, i, fr_word[i], ref_frame(exp_code[i]));
                end
            end
        end
        total++;
        if (ovr_cyc.size() != 1 || exp_ovr_cyc.size() != 1) begin
            bad++;
            $display("FAIL ovr_pulses unit=%0d got=%0d required=1", u, ovr_cyc.size());
        end else begin
            total++;
            if (ovr_cyc[0] != exp_ovr_cyc[0]) begin
                bad++;
                $display("FAIL ovr_timing unit=%0d got=%0d required=%0d", u, ovr_cyc[0], exp_ovr_cyc[0]);
            end
        end
    endtask

    task automatic test_reset_mid(input int u);
        int c;
        clr_mon(u);
        push_stim(16'($urandom), 0, 1'b0);
        push_stim(16'($urandom), 0, 1'b0);
        for (c = 0; c < 1000; c++) begin
            step(u);
            if (!cs_n[u] && cur_rises == 8) break;
        end
        total++;
        if (c >= 1000) begin
            bad++;
            $display("FAIL mid_reach_bit7 unit=%0d got=%0d cycles required=<1000", u, c);
        end
        total++;
        if (din_ready[u] !== 1'b0) begin
            bad++;
            $display("FAIL mid_buffer_full unit=%0d got=%b required=0", u, din_ready[u]);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({cs_n[u], sclk[u], frame_done[u], busy[u], din_ready[u]} !== 5'b10001) begin
            bad++;
            $display("FAIL mid_abort unit=%0d got=%b required=10001", u,
                     {cs_n[u], sclk[u], frame_done[u], busy[u], din_ready[u]});
        end
        total++;
        if (last_code[u] !== 8'h80) begin
            bad++;
            $display("FAIL mid_last_code unit=%0d got=%h required=80", u, last_code[u]);
        end
        reset = 1'b0;
        clr_mon(u);
        for (int i = 0; i < 60; i++) step(u);
        total++;
        if (fr_start.size() != 0 || done_cnt != 0) begin
            bad++;
            $display("FAIL mid_discard unit=%0d got=frames%0d/done%0d required=0/0", u, fr_start.size(), done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_codes(0);
        test_codes(1);
        test_back_to_back(0);
        test_back_to_back(1);
        test_overrun(0);
        test_overrun(1);
        test_reset_mid(0);
        test_reset_mid(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
